// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access-size codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half lane from a memory word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_i[8*off_i +: 8];
        half_sel = off_i[1] ? rd_i[31:16] : rd_i[15:0];
        case (size_i)
            LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: data_o = {24'd0, byte_sel};
            LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: data_o = {16'd0, half_sel};
            default: data_o = rd_i;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: legality check, store lane formatting, and a two-state handshake
// that stalls the core until the word memory responds.
module lsu_unit
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    lsu_state_e  state_q, state_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        load_q, load_d;
    logic        illegal, misaligned;
    logic [31:0] load_data;

    function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B:  store_be = 4'b0001 << off;
            LDST_H:  store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            LDST_B:  store_wd = {4{wd[7:0]}};
            LDST_H:  store_wd = {2{wd[15:0]}};
            default: store_wd = wd;
        endcase
    endfunction

    always_comb begin
        illegal = (core_size_i == 3'd3) || (core_size_i == 3'd6) || (core_size_i == 3'd7) ||
                  (core_we_i && ((core_size_i == LDST_BU) || (core_size_i == LDST_HU)));
        misaligned = ((core_size_i == LDST_W) && (core_addr_i[1:0] != 2'b00)) ||
                     (((core_size_i == LDST_H) || (core_size_i == LDST_HU)) && core_addr_i[0]);
    end

    lsu_load_align u_load_align (
        .rd_i   (mem_rd_i),
        .size_i (size_q),
        .off_i  (off_q),
        .data_o (load_data)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        off_d        = off_q;
        load_d       = load_q;
        core_rd_o    = 32'd0;
        core_stall_o = 1'b0;
        fault_o      = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'd0;
        mem_addr_o   = 32'd0;
        mem_wd_o     = 32'd0;
        // Outputs are gated by rst_ni so an asserted reset silences them immediately.
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (core_req_i) begin
                        if (illegal || misaligned) begin
                            fault_o = 1'b1;
                        end else begin
                            mem_req_o    = 1'b1;
                            core_stall_o = 1'b1;
                            mem_we_o     = core_we_i;
                            mem_addr_o   = {core_addr_i[31:2], 2'b00};
                            if (core_we_i) begin
                                mem_be_o = store_be(core_size_i, core_addr_i[1:0]);
                                mem_wd_o = store_wd(core_size_i, core_wd_i);
                            end
                            size_d  = core_size_i;
                            off_d   = core_addr_i[1:0];
                            load_d  = ~core_we_i;
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    core_stall_o = ~mem_ready_i;
                    if (mem_ready_i) begin
                        state_d = IDLE;
                        if (load_q) begin
                            core_rd_o = load_data;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            load_q  <= load_d;
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed vector table, randomized accesses against
// a byte-level reference model, and hand-written wait-state and reset sequences.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd;
    logic [31:0] core_rd;
    logic        core_stall, fault;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_ready;

    int checks = 0;
    int failures = 0;
    int req_pulses = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req) req_pulses++;

    lsu_unit dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .fault_o      (fault),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready)
    );

    typedef struct {
        bit          we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] word;
        bit          exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".rd"},    core_rd, 32'd0);
        chk({name, ".stall"}, {31'd0, core_stall}, 32'd0);
        chk({name, ".fault"}, {31'd0, fault}, 32'd0);
        chk({name, ".req"},   {31'd0, mem_req}, 32'd0);
        chk({name, ".we"},    {31'd0, mem_we}, 32'd0);
        chk({name, ".be"},    {28'd0, mem_be}, 32'd0);
        chk({name, ".addr"},  mem_addr, 32'd0);
        chk({name, ".wd"},    mem_wd, 32'd0);
    endtask

    // Reference model: reasons in bytes and lanes rather than in encodings.
    function automatic int m_bytes(input logic [2:0] sz);
        return 1 << sz[1:0];
    endfunction

    function automatic bit m_bad(input bit we, input logic [2:0] sz, input logic [31:0] a);
        if (sz == 3 || sz >= 6) return 1'b1;
        if (we && sz[2]) return 1'b1;
        return (a % m_bytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
        logic [3:0] be = 4'd0;
        for (int i = 0; i < 4; i++)
            if (i >= a % 4 && i < a % 4 + m_bytes(sz)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> ((i % m_bytes(sz)) * 8)) & 32'hFF) << (i * 8));
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] word);
        longint unsigned mask, val;
        int n = m_bytes(sz);
        mask = (64'd1 << (8 * n)) - 1;
        val  = (longint'(word) >> ((a % 4) * 8)) & mask;
        if (!sz[2] && ((val >> (8 * n - 1)) & 1) != 0) val = val | ~mask;
        return val[31:0];
    endfunction

    // One complete access; expectations are supplied by the caller.
    task automatic access(input string name, input bit we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                          input int waits, input bit e_fault, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic [31:0] e_rd);
        int pulses0;
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = wd;
        mem_ready = 1'b0; mem_rd = 32'd0;
        pulses0 = req_pulses;
        #1;
        chk({name, ".fault"}, {31'd0, fault}, {31'd0, e_fault});
        if (e_fault) begin
            chk({name, ".req"},   {31'd0, mem_req}, 32'd0);
            chk({name, ".stall"}, {31'd0, core_stall}, 32'd0);
            @(negedge clk);
            core_req = 1'b0;
            #1;
            chk({name, ".fault_gone"}, {31'd0, fault}, 32'd0);
            chk({name, ".no_pulse"}, req_pulses - pulses0, 32'd0);
            return;
        end
        chk({name, ".req"},   {31'd0, mem_req}, 32'd1);
        chk({name, ".stall"}, {31'd0, core_stall}, 32'd1);
        chk({name, ".we"},    {31'd0, mem_we}, {31'd0, we});
        chk({name, ".addr"},  mem_addr, a & 32'hFFFF_FFFC);
        chk({name, ".be"},    {28'd0, mem_be}, {28'd0, e_be});
        chk({name, ".wd"},    mem_wd, e_wd);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk); #1;
            chk({name, ".wait_stall"}, {31'd0, core_stall}, 32'd1);
            chk({name, ".wait_req"},   {31'd0, mem_req}, 32'd0);
        end
        @(negedge clk);
        mem_ready = 1'b1; mem_rd = word;
        #1;
        chk({name, ".resp_stall"}, {31'd0, core_stall}, 32'd0);
        chk({name, ".resp_req"},   {31'd0, mem_req}, 32'd0);
        chk({name, ".resp_rd"},    core_rd, e_rd);
        @(negedge clk);
        core_req = 1'b0; mem_ready = 1'b0; mem_rd = 32'd0;
        chk({name, ".pulses"}, req_pulses - pulses0, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'h0, 32'h0,        32'hDEADBEEF},
            '{0, 3'd0, 32'h103, 32'h0,        32'h80112233, 0, 4'h0, 32'h0,        32'hFFFFFF80},
            '{0, 3'd4, 32'h103, 32'h0,        32'h80112233, 0, 4'h0, 32'h0,        32'h00000080},
            '{0, 3'd1, 32'h102, 32'h0,        32'h80112233, 0, 4'h0, 32'h0,        32'hFFFF8011},
            '{0, 3'd5, 32'h100, 32'h0,        32'h80112233, 0, 4'h0, 32'h0,        32'h00002233},
            '{1, 3'd0, 32'h201, 32'h123456AB, 32'h0,        0, 4'h2, 32'hABABABAB, 32'h0},
            '{1, 3'd1, 32'h202, 32'hFFFF1234, 32'h0,        0, 4'hC, 32'h12341234, 32'h0},
            '{1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0,        0, 4'hF, 32'hCAFEF00D, 32'h0},
            '{0, 3'd2, 32'h102, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0},
            '{1, 3'd1, 32'h101, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0},
            '{0, 3'd3, 32'h100, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0},
            '{1, 3'd4, 32'h100, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0},
            '{0, 3'd5, 32'h103, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0}
        };

        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h100;
        core_wd = 32'h0; mem_rd = 32'h0; mem_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        core_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            access($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd,
                   vecs[i].word, 0, vecs[i].exp_fault, vecs[i].exp_be, vecs[i].exp_wd, vecs[i].exp_rd);

        // Three extra wait cycles: four stalled cycles, one request pulse.
        access("lw_wait3", 1'b0, 3'd2, 32'h400, 32'h0, 32'h5A5AA5A5, 3, 1'b0, 4'h0, 32'h0, 32'h5A5AA5A5);

        // Randomized accesses against the reference model.
        for (int k = 0; k < 150; k++) begin
            bit          we;
            logic [2:0]  sz;
            logic [31:0] a, wd, word;
            bit          bad;
            we   = $urandom_range(0, 1);
            sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'(($urandom_range(0, 4) >= 3) ? $urandom_range(4, 5) : $urandom_range(0, 2));
            a    = $urandom;
            wd   = $urandom;
            word = $urandom;
            bad  = m_bad(we, sz, a);
            access($sformatf("rnd%0d", k), we, sz, a, wd, word, $urandom_range(0, 2), bad,
                   we ? m_be(sz, a) : 4'h0, we ? m_wd(sz, wd) : 32'h0,
                   (!we && !bad) ? m_rd(sz, a, word) : 32'h0);
        end

        // Reset while BUSY: outputs drop at once and a late ready is ignored.
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h500; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst.busy_stall", {31'd0, core_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst.asserted");
        @(negedge clk);
        core_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1; mem_rd = 32'hFEEDFACE;
        #1;
        chk_all_zero("midrst.late_ready");
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk_all_zero("midrst.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit between the core's memory-stage signals and the word-organised data memory (byte-addressed, 32-bit words, one-cycle registered read). It converts byte/half/word loads and stores into word-aligned memory transactions with byte enables. It stalls the core until the memory responds, then sign- or zero-extends load data. Misaligned or illegal accesses are rejected before reaching memory.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  load/store request, held by core while core_stall_o=1
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  access size, funct3 encoding: B=0, H=1, W=2, BU=4, HU=5
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-justified
- core_rd_o  out  32  extended load data, valid only in the response cycle
- core_stall_o  out  1  core must hold its memory-stage inputs
- fault_o  out  1  one-cycle pulse on a misaligned or illegal access
- mem_req_o  out  1  single-cycle memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables, bit n = byte lane n
- mem_addr_o  out  32  core_addr_i with bits [1:0] forced to 0
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  response valid this cycle; mem_rd_i valid for loads

## Operation
- States: IDLE, BUSY. Registers: state, size_q[2:0], off_q[1:0].
- Legality checks:
  - Misaligned: W with addr[1:0]≠0, or H/HU with addr[0]≠0.
  - Illegal: size 3, 6 or 7, or a store with size BU/HU.
- IDLE with core_req_i=1 and a legal access:
  - mem_req_o=1 and core_stall_o=1, both combinational.
  - Latch size and addr[1:0] into size_q/off_q.
  - Go to BUSY.
- IDLE with core_req_i=1 and an illegal or misaligned access:
  - fault_o=1, mem_req_o=0, core_stall_o=0.
  - Stay in IDLE; the core's trap logic owns the rest.
- BUSY:
  - mem_req_o=0 and core_stall_o = ~mem_ready_i.
  - On mem_ready_i=1, return to IDLE. For a load, core_rd_o is driven from mem_rd_i using size_q/off_q.
- Store formatting:
  - B: mem_wd_o={4{wd[7:0]}}, mem_be_o=4'b0001<<addr[1:0].
  - H: mem_wd_o={2{wd[15:0]}}, mem_be_o = addr[1] ? 4'b1100 : 4'b0011.
  - W: mem_wd_o=wd, mem_be_o=4'b1111.
- Load extraction:
  - Select the byte lane off_q (B/BU) or the half lane off_q[1] (H/HU).
  - Sign-extend for B/H, zero-extend for BU/HU. W passes through.
- When no load response is being delivered, core_rd_o=0.
- mem_we_o, mem_be_o, mem_wd_o and mem_addr_o are 0 whenever mem_req_o=0.
- mem_ready_i is ignored in IDLE.

## Timing
- Reset (asynchronous, active-low):
  - state=IDLE, size_q=0, off_q=0.
  - All outputs 0, including core_stall_o.
- Reset mid-BUSY abandons the transaction; a late mem_ready_i after reset is ignored.
- Minimum latency is 2 cycles: the request cycle (stalled), then the response cycle (mem_ready_i=1, stall low, data valid). The core advances on the response edge.
- Memory with registered ready (ready = req delayed one cycle) gives exactly 2 cycles per access. Each extra wait cycle adds one stalled cycle.
- Back-to-back accesses: a new request is accepted in the cycle after the response. There is no overlap; at most one transaction is outstanding.
- fault_o is combinational in the cycle the bad request is presented. It never asserts while BUSY.

## Structure
- Package lsu_pkg holds:
  - size constants LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU
  - the IDLE/BUSY state enum
- Sub-module lsu_load_align is purely combinational. It takes mem_rd_i, size_q and off_q and produces the extended 32-bit word.
- Store formatting and the FSM stay in lsu_unit.

## Test plan
- LW at 0x100; memory returns 0xDEADBEEF next cycle:
  - request cycle: stall=1, mem_addr_o=0x100, be=0
  - response cycle: stall=0, core_rd_o=0xDEADBEEF
- LB and LBU at 0x103 with word 0x80112233:
  - LB gives 0xFFFFFF80; LBU gives 0x00000080.
  - LH at 0x102 gives 0xFFFF8011; LHU at 0x100 gives 0x00002233.
- Store formatting:
  - SB 0xAB at 0x201: mem_wd_o=0xABABABAB, be=4'b0010, we=1.
  - SH 0x1234 at 0x202: be=4'b1100, wd=0x12341234.
- LW at 0x102 or SH at 0x101: fault_o=1 for one cycle, mem_req_o=0, stall=0, state stays IDLE.
- mem_ready_i delayed 3 cycles: stall held for 4 cycles, mem_req_o pulsed exactly once, correct data on the ready cycle.
- rst_ni pulled low while BUSY: all outputs 0 immediately; a mem_ready_i arriving after release produces no response and no stall.
